// File: rtl/hatch_sequencer.sv
// rtl/hatch_sequencer.sv - egg-hatch display sequencer: timed incubation stages, temperature fault handling
module hatch_sequencer #(
    parameter int NUM_STAGES     = 12,
    parameter int TICK_DIV       = 1000,
    parameter int STAGE_SEC      = 5,
    parameter int TEMP_FAULT_SEC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       temp_ok,
    output logic [3:0] num,
    output logic       st,
    output logic       temp_alarm,
    output logic       done,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
    localparam int BW = (TEMP_FAULT_SEC > 1) ? $clog2(TEMP_FAULT_SEC) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(STAGE_SEC - 1);
    localparam logic [BW-1:0] BAD_MAX   = BW'(TEMP_FAULT_SEC - 1);
    localparam logic [3:0]    NUM_LAST  = 4'(NUM_STAGES - 1);
    localparam logic [3:0]    NUM_PEN   = 4'(NUM_STAGES - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [3:0]    num_d;
    logic          st_d, alarm_d, done_d;
    logic          tick;

    assign state = state_q;
    assign tick  = (presc_q == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            bad_q      <= '0;
            num        <= 4'd0;
            st         <= 1'b0;
            temp_alarm <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            bad_q      <= bad_d;
            num        <= num_d;
            st         <= st_d;
            temp_alarm <= alarm_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        bad_d   = bad_q;
        num_d   = num;
        st_d    = st;
        alarm_d = temp_alarm;
        done_d  = done;

        case (state_q)
            S_IDLE: begin
                st_d    = 1'b0;
                num_d   = 4'd0;
                alarm_d = 1'b0;
                done_d  = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    sec_d   = '0;
                    bad_d   = '0;
                    st_d    = 1'b1;
                end
            end
            S_RUN: begin
                st_d    = 1'b1;
                alarm_d = ~temp_ok;
                // A pause on the tick cycle leaves presc at its max so the tick is retaken on resume
                if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (temp_ok) begin
                            bad_d = '0;
                            if (sec_q == SEC_MAX) begin
                                sec_d = '0;
                                num_d = num + 4'd1;
                                if (num == NUM_PEN) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                    alarm_d = 1'b0;
                                end
                            end else begin
                                sec_d = sec_q + SW'(1);
                            end
                        end else if (bad_q == BAD_MAX) begin
                            state_d = S_FAULT;
                            alarm_d = 1'b1;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end
                end
            end
            S_PAUSE: begin
                st_d = 1'b1;
                if (pause) state_d = S_RUN;
            end
            S_DONE: begin
                st_d    = 1'b1;
                num_d   = NUM_LAST;
                done_d  = 1'b1;
                alarm_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                    sec_d   = '0;
                    bad_d   = '0;
                    num_d   = 4'd0;
                    done_d  = 1'b0;
                end
            end
            S_FAULT: begin
                st_d    = 1'b1;
                alarm_d = 1'b1;
                if (start) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    sec_d   = '0;
                    bad_d   = '0;
                    num_d   = 4'd0;
                    alarm_d = 1'b0;
                    st_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hatch_sequencer.sv
// tb/tb_hatch_sequencer.sv - scoreboard bench for hatch_sequencer with a short tick (TICK_DIV=4)
module tb_hatch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       temp_ok = 1'b1;
    logic [3:0] num;
    logic       st, temp_alarm, done;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int num;
        int cyc;
    } exp_t;
    exp_t sb[$];

    hatch_sequencer #(
        .NUM_STAGES(12),
        .TICK_DIV(4),
        .STAGE_SEC(2),
        .TEMP_FAULT_SEC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .temp_ok(temp_ok),
        .num(num),
        .st(st),
        .temp_alarm(temp_alarm),
        .done(done),
        .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic push_exp(input int n, input int c);
        exp_t e;
        e.num = n;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Wait (bounded) for each num change and compare it with the next scoreboard entry
    task automatic drain_sb(input int budget);
        logic [3:0] prev;
        bit         found;
        exp_t       e;
        while (sb.size() > 0) begin
            prev  = num;
            found = 1'b0;
            for (int i = 0; i < budget && !found; i++) begin
                @(negedge clk);
                if (num != prev) found = 1'b1;
            end
            e = sb.pop_front();
            if (!found) begin
                check("num_timeout", 32'(num), 32'(e.num));
                sb.delete();
            end else begin
                check("num_value", 32'(num), 32'(e.num));
                check("num_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    initial begin
        int c0, p, p4, r;
        bit found;

        // reset state
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_num", 32'(num), 0);
        check("rst_st", 32'(st), 0);
        check("rst_alarm", 32'(temp_alarm), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        pulse_pause();
        check("idle_pause_ign", 32'(state), 0);

        // start, then start again mid-run (ignored)
        pulse_start();
        c0 = cyc;
        check("run_state", 32'(state), 1);
        check("run_st", 32'(st), 1);
        step(2);
        pulse_start();
        check("run_start_ign", 32'(state), 1);
        push_exp(1, c0 + 8);
        push_exp(2, c0 + 16);
        push_exp(3, c0 + 24);
        drain_sb(40);

        // pause lands on the tick cycle: tick must be deferred until resume
        step(3);
        pulse_pause();
        check("pause_state", 32'(state), 2);
        step(19);
        pulse_start();
        check("pause_num", 32'(num), 3);
        check("pause_start_ign", 32'(state), 2);
        pulse_pause();
        p = cyc;
        check("resume_state", 32'(state), 1);
        push_exp(4, p + 5);
        drain_sb(40);
        p4 = cyc;

        // two bad ticks: no fault, stage advance delayed by 8
        temp_ok = 1'b0;
        step(1);
        check("bad_alarm", 32'(temp_alarm), 1);
        step(7);
        check("bad_no_fault", 32'(state), 1);
        check("bad_num_frozen", 32'(num), 4);
        temp_ok = 1'b1;
        step(1);
        check("good_alarm", 32'(temp_alarm), 0);
        push_exp(5, p4 + 16);
        push_exp(6, p4 + 24);
        drain_sb(40);
        r = cyc;

        // three bad ticks at num=6 -> FAULT
        temp_ok = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd4) found = 1'b1;
        end
        check("fault_seen", 32'(found), 1);
        check("fault_cycle", 32'(cyc), 32'(r + 12));
        check("fault_num", 32'(num), 6);
        check("fault_alarm", 32'(temp_alarm), 1);
        check("fault_st", 32'(st), 1);
        temp_ok = 1'b1;
        pulse_pause();
        check("fault_pause_ign", 32'(state), 4);
        pulse_start();
        check("fault_ack_state", 32'(state), 0);
        check("fault_ack_num", 32'(num), 0);
        check("fault_ack_st", 32'(st), 0);
        check("fault_ack_alarm", 32'(temp_alarm), 0);

        // full run to DONE, start and pause together from IDLE
        start = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        c0 = cyc;
        check("both_idle_state", 32'(state), 1);
        for (int k = 1; k <= 11; k++) push_exp(k, c0 + 8 * k);
        drain_sb(40);
        check("done_flag", 32'(done), 1);
        check("done_state", 32'(state), 3);
        check("done_alarm", 32'(temp_alarm), 0);
        step(20);
        check("done_hold_num", 32'(num), 11);
        check("done_hold_flag", 32'(done), 1);

        // restart from DONE
        pulse_start();
        c0 = cyc;
        check("restart_state", 32'(state), 1);
        check("restart_num", 32'(num), 0);
        check("restart_done", 32'(done), 0);
        for (int k = 1; k <= 5; k++) push_exp(k, c0 + 8 * k);
        drain_sb(40);

        // async reset mid-run at num=5
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_num", 32'(num), 0);
        check("arst_st", 32'(st), 0);
        check("arst_alarm", 32'(temp_alarm), 0);
        check("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
